pingpong_counter: RTL and testbench

//  Parametrised up/down counter with programmable bounds [lo,hi] and run-time mode:
//  up-wrap, down-wrap, bounce (ping-pong) or hold. Generalises the fixed 3-bit

---
 rtl/pingpong_counter_pkg.sv | 13 +
 rtl/pingpong_counter_next.sv | 72 +++++++
 rtl/pingpong_counter.sv | 105 ++++++++++
 tb/tb_pingpong_counter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_counter_pkg.sv
// Shared definitions for the pingpong_counter slice: mode encodings and dwell width.
package pingpong_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UPWRAP = 2'b00,
    MODE_DNWRAP = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int unsigned DWELL_W = 4;

endpackage

// File: rtl/pingpong_counter_next.sv
// Combinational next-value calculation: next q, next direction and turn/wrap events.
module pingpong_counter_next
  import pingpong_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir_up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             dwell_hold,
  output logic [WIDTH-1:0] q_c,
  output logic             dir_up_c,
  output logic             turn_c,
  output logic             wrap_c
);

  always_comb begin
    q_c      = q;
    dir_up_c = dir_up;
    turn_c   = 1'b0;
    wrap_c   = 1'b0;
    // Degenerate bounds or an out-of-range q both restart the sweep at lo
    if ((lo >= hi) || (q < lo) || (q > hi)) begin
      q_c      = lo;
      dir_up_c = 1'b1;
    end else begin
      case (mode_e'(mode))
        MODE_UPWRAP: begin
          dir_up_c = 1'b1;
          if (q == hi) begin
            q_c    = lo;
            wrap_c = 1'b1;
          end else begin
            q_c = q + WIDTH'(1);
          end
        end
        MODE_DNWRAP: begin
          dir_up_c = 1'b0;
          if (q == lo) begin
            q_c    = hi;
            wrap_c = 1'b1;
          end else begin
            q_c = q - WIDTH'(1);
          end
        end
        MODE_BOUNCE: begin
          if (dir_up) begin
            if (q != hi) begin
              q_c = q + WIDTH'(1);
            end else if (!dwell_hold) begin
              q_c      = hi - WIDTH'(1);
              dir_up_c = 1'b0;
              turn_c   = 1'b1;
            end
          end else begin
            if (q != lo) begin
              q_c = q - WIDTH'(1);
            end else if (!dwell_hold) begin
              q_c      = lo + WIDTH'(1);
              dir_up_c = 1'b1;
              turn_c   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pingpong_counter.sv
// Bounded up/down/bounce counter with load, enable and turn/wrap pulses.
// Define PINGPONG_CNT_DWELL_EN to add the dwell input (endpoint hold in bounce mode).
module pingpong_counter
  import pingpong_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
`ifdef PINGPONG_CNT_DWELL_EN
  input  logic [DWELL_W-1:0] dwell,
`endif
  output logic [WIDTH-1:0]   q,
  output logic               dir_up,
  output logic               at_lo,
  output logic               at_hi,
  output logic               turn,
  output logic               wrap
);

  logic [WIDTH-1:0] q_c;
  logic             dir_up_c;
  logic             turn_c;
  logic             wrap_c;
  logic             count_c;
  logic             dwell_hold_c;

  assign count_c = en && (mode_e'(mode) != MODE_HOLD) && !load;
  assign at_lo   = (q == lo);
  assign at_hi   = (q == hi);

  pingpong_counter_next #(.WIDTH(WIDTH)) u_next (
    .q          (q),
    .dir_up     (dir_up),
    .mode       (mode),
    .lo         (lo),
    .hi         (hi),
    .dwell_hold (dwell_hold_c),
    .q_c        (q_c),
    .dir_up_c   (dir_up_c),
    .turn_c     (turn_c),
    .wrap_c     (wrap_c)
  );

`ifdef PINGPONG_CNT_DWELL_EN
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_eff_c;
  logic [1:0]         mode_q;
  logic               at_end_c;

  // A mode change this edge discards any partially accumulated dwell
  always_comb begin
    dwell_eff_c  = (mode != mode_q) ? '0 : dwell_cnt;
    dwell_hold_c = (dwell_eff_c < dwell);
    at_end_c     = (mode_e'(mode) == MODE_BOUNCE) && (lo < hi) &&
                   (dir_up ? (q == hi) : (q == lo));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
      mode_q    <= 2'(MODE_UPWRAP);
    end else begin
      mode_q <= mode;
      if (load)
        dwell_cnt <= '0;
      else if (count_c)
        dwell_cnt <= (at_end_c && dwell_hold_c) ? dwell_eff_c + DWELL_W'(1) : '0;
      else
        dwell_cnt <= dwell_eff_c;
    end
  end
`else
  assign dwell_hold_c = 1'b0;
`endif

  // Pulses default low; only a counting edge may raise them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= RST_VAL;
      dir_up <= 1'b1;
      turn   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      turn <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        q <= load_val;
      end else if (count_c) begin
        q      <= q_c;
        dir_up <= dir_up_c;
        turn   <= turn_c;
        wrap   <= wrap_c;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_counter.sv
// Self-checking bench for pingpong_counter: directed sequences plus randomized traffic
// against a behavioural model. Dwell checks run when PINGPONG_CNT_DWELL_EN is defined.
module tb_pingpong_counter;

  localparam int unsigned      WIDTH   = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 3'd0;
`ifdef PINGPONG_CNT_DWELL_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             en       = 1'b0;
  logic [1:0]       mode     = 2'd2;
  logic [WIDTH-1:0] lo       = '0;
  logic [WIDTH-1:0] hi       = 3'd7;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [3:0]       dwell    = 4'd0;
  logic [WIDTH-1:0] q;
  logic             dir_up, at_lo, at_hi, turn, wrap;

  pingpong_counter #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
`ifdef PINGPONG_CNT_DWELL_EN
    .dwell    (dwell),
`endif
    .q        (q),
    .dir_up   (dir_up),
    .at_lo    (at_lo),
    .at_hi    (at_hi),
    .turn     (turn),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer arithmetic straight from the counting rules
  int m_q, m_dir, m_turn, m_wrap, m_dcnt, m_pm;
  int l, h, md, endpt, dw;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q = RST_VAL; m_dir = 1; m_turn = 0; m_wrap = 0; m_dcnt = 0; m_pm = 0;
    end else begin
      l = lo; h = hi; md = mode;
      dw = DWELL_ON ? int'(dwell) : 0;
      m_turn = 0; m_wrap = 0;
      if (md != m_pm) m_dcnt = 0;
      m_pm = md;
      if (load) begin
        m_q = load_val; m_dcnt = 0;
      end else if (en && md != 3) begin
        if (l >= h || m_q < l || m_q > h) begin
          m_q = l; m_dir = 1; m_dcnt = 0;
        end else if (md == 0) begin
          m_dir = 1; m_dcnt = 0;
          if (m_q == h) begin m_q = l; m_wrap = 1; end else m_q = m_q + 1;
        end else if (md == 1) begin
          m_dir = 0; m_dcnt = 0;
          if (m_q == l) begin m_q = h; m_wrap = 1; end else m_q = m_q - 1;
        end else begin
          endpt = m_dir ? h : l;
          if (m_q != endpt) begin
            m_dcnt = 0;
            m_q = m_dir ? m_q + 1 : m_q - 1;
          end else if (m_dcnt < dw) begin
            m_dcnt++;
          end else begin
            m_dcnt = 0;
            m_dir = m_dir ? 0 : 1;
            m_q = m_dir ? l + 1 : h - 1;
            m_turn = 1;
          end
        end
      end
    end
  end

  // Compare process: every falling edge once enabled
  always @(negedge clk) begin
    if (chk_on) begin
      chk("q", q, m_q);
      chk("dir_up", dir_up, m_dir);
      chk("turn", turn, m_turn);
      chk("wrap", wrap, m_wrap);
      chk("at_lo", at_lo, int'(m_q == int'(lo)));
      chk("at_hi", at_hi, int'(m_q == int'(hi)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_exp(input string name, input int exp);
    tick();
    chk(name, q, exp);
  endtask

  int t1 [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int t2u [5] = '{3, 4, 5, 2, 3};
  int t2d [4] = '{2, 5, 4, 3};
  int t6 [11] = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};

  initial begin
    #12;
    chk("rst_q", q, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_turn", turn, 0);
    chk("rst_wrap", wrap, 0);
    chk_on = 1'b1;
    mode = 2'd2; lo = 3'd0; hi = 3'd7; en = 1'b1;
    reset = 1'b0;

    // Full bounce sweep from reset
    for (int i = 0; i < 15; i++) begin
      tick_exp("t1_q", t1[i]);
      if (i == 7 || i == 14) chk("t1_turn", turn, 1);
    end

    // Up-wrap then down-wrap within [2,5]
    mode = 2'd0; lo = 3'd2; hi = 3'd5; load = 1'b1; load_val = 3'd2;
    tick_exp("t2_load", 2);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_exp("t2_up", t2u[i]);
      if (i == 3) chk("t2_wrap_up", wrap, 1);
    end
    mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick_exp("t2_dn", t2d[i]);
      if (i == 1) chk("t2_wrap_dn", wrap, 1);
    end

    // Out-of-range load corrected on next counting edge, even in down-wrap
    lo = 3'd1; hi = 3'd4; load = 1'b1; load_val = 3'd6;
    tick_exp("t3_load", 6);
    load = 1'b0;
    tick_exp("t3_fix", 1);
    chk("t3_dir", dir_up, 1);
    chk("t3_wrap", wrap, 0);

    // Enable low holds; load beats enable
    mode = 2'd2; lo = 3'd0; hi = 3'd7; load = 1'b1; load_val = 3'd5;
    tick_exp("t4_load", 5);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_exp("t4_hold", 5);
      chk("t4_turn", turn, 0);
    end
    en = 1'b1; load = 1'b1; load_val = 3'd7;
    tick_exp("t4_loadwins", 7);
    load = 1'b0;
    tick_exp("t5_down", 6);
    chk("t5_dir", dir_up, 0);

    // Asynchronous reset mid-sweep
    reset = 1'b1;
    #1;
    chk("t5_rst_q", q, RST_VAL);
    chk("t5_rst_dir", dir_up, 1);
    #1;
    reset = 1'b0;
    lo = 3'd3; hi = 3'd3;
    for (int i = 0; i < 3; i++) tick_exp("t5_lohi", 3);
    mode = 2'd0;
    tick_exp("t5_lohi_up", 3);

    if (DWELL_ON) begin
      reset = 1'b1;
      tick();
      mode = 2'd2; lo = 3'd0; hi = 3'd3; dwell = 4'd2; en = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 11; i++) tick_exp("t6_dwell", t6[i]);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset = 1'b0;
      en   = ($urandom_range(0, 99) < 85);
      load = ($urandom_range(0, 99) < 5);
      load_val = WIDTH'($urandom);
      if ($urandom_range(0, 99) < 8) mode = 2'($urandom);
      if ($urandom_range(0, 99) < 5) begin
        lo = WIDTH'($urandom_range(0, 4));
        hi = WIDTH'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) < 5) dwell = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    tick();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
